// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
// Holds the receive FSM state encoding, the per-character flag bit
// positions and the frame-format defaults, plus the data-bit normaliser.
package uart_pkg;

  // Receive FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP1  = 3'd4;
  localparam logic [2:0] ST_STOP2  = 3'd5;
  localparam logic [2:0] ST_BREAK  = 3'd6;

  // Per-character flag positions inside the 3-bit flag field
  localparam int unsigned FLAGS_W  = 3;
  localparam int unsigned FLAG_BRK = 2;
  localparam int unsigned FLAG_FE  = 1;
  localparam int unsigned FLAG_PE  = 0;

  // Frame-format defaults
  localparam logic [3:0] CFG_BITS_DEFAULT = 4'd8;

  // Data-bit count outside 5..9 falls back to the default width
  function automatic logic [3:0] norm_bits(input logic [3:0] bits);
    return ((bits >= 4'd5) && (bits <= 4'd9)) ? bits : CFG_BITS_DEFAULT;
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// rx_sync_fifo: single-clock first-word-fall-through FIFO.
// Ports: clk, rst (sync active-low), push/wdata write side, pop read side,
// rdata always shows the head entry, empty/full status and occupancy level.
// A push while full is accepted only when a pop happens in the same cycle.
module rx_sync_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers (wrap naturally for power-of-two depth) and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[PTR_W'(i)] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign level = count;

endmodule

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: oversampled UART receiver with runtime frame format.
// Ports: clk, rst (sync active-low); AcqSig_i oversample tick; Rx_i serial
// line; cfg_data_bits_i / p_ParityEnable_i / ParityMethod_i / p_TwoStop_i /
// p_BigEnd_i frame format (latched at each start edge); n_rd_i active-low
// pop; data_o/flags_o head entry {break, frame_err, parity_err};
// p_empty_o/level_o FIFO status; p_OverrunError_o sticky overrun cleared by
// clr_overrun_i; p_Timeout_o idle receive timeout.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 9,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          AcqSig_i,
  input  logic                          Rx_i,
  input  logic [3:0]                    cfg_data_bits_i,
  input  logic                          p_ParityEnable_i,
  input  logic                          ParityMethod_i,
  input  logic                          p_TwoStop_i,
  input  logic                          p_BigEnd_i,
  input  logic                          n_rd_i,
  output logic [DATA_W-1:0]             data_o,
  output logic [2:0]                    flags_o,
  output logic                          p_empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          p_OverrunError_o,
  input  logic                          clr_overrun_i,
  output logic                          p_Timeout_o
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned MID    = OVERSAMPLE / 2;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_BITS + 1);
  localparam int unsigned WORD_W = DATA_W + FLAGS_W;

  logic               sync1, sync2, rx_prev;
  logic [2:0]         state_q, state_d;
  logic [TICK_W-1:0]  tick_q;
  logic               samp_a, samp_b;
  logic [3:0]         bits_q, bit_idx_q;
  logic               pen_q, podd_q, two_q, msb_q;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               zero_q, pe_q, fe_q;
  logic               push_q;
  logic [WORD_W-1:0]  word_q;
  logic               ovr_q, to_q;
  logic [TO_W-1:0]    to_cnt_q;

  logic               start_edge_c, decide_c, bit_end_c, vote_c, last_data_c;
  logic               frame_done_c, is_break_c, pop_c;
  logic [3:0]         bit_pos_c;
  logic [FLAGS_W-1:0] flags_c;
  logic [WORD_W-1:0]  head;
  logic               empty, full;

  // Start edge needs a 1 seen before the 0, so a held-low line never re-triggers
  assign start_edge_c = (state_q == ST_IDLE) && rx_prev && !sync2;
  assign decide_c     = AcqSig_i && (tick_q == TICK_W'(MID + 1));
  assign bit_end_c    = AcqSig_i && (tick_q == TICK_W'(OVERSAMPLE - 1));
  // Two stored samples plus the current synchronised line at the decision tick
  assign vote_c       = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);
  assign last_data_c  = (bit_idx_q == (bits_q - 4'd1));
  assign pop_c        = !n_rd_i && !empty;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and frame-completion decode
  always_comb begin
    state_d      = state_q;
    frame_done_c = 1'b0;
    is_break_c   = 1'b0;
    case (state_q)
      ST_IDLE:   if (start_edge_c) state_d = ST_START;
      ST_START:  if (decide_c) state_d = vote_c ? ST_IDLE : ST_DATA;
      ST_DATA:   if (decide_c && last_data_c) state_d = pen_q ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (decide_c) state_d = ST_STOP1;
      ST_STOP1: begin
        if (decide_c) begin
          if (!vote_c && zero_q) begin
            frame_done_c = 1'b1;
            is_break_c   = 1'b1;
            state_d      = ST_BREAK;
          end else if (two_q) begin
            state_d = ST_STOP2;
          end else begin
            frame_done_c = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      ST_STOP2: begin
        if (decide_c) begin
          frame_done_c = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_BREAK:  if (sync2) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Data bit placement (LSB-first or MSB-first) and flags of the finished character
  always_comb begin
    bit_pos_c = msb_q ? (bits_q - 4'd1 - bit_idx_q) : bit_idx_q;
    shreg_d   = shreg_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (bit_pos_c == 4'(i)) shreg_d[i] = vote_c;
    end
    flags_c          = '0;
    flags_c[FLAG_BRK] = is_break_c;
    flags_c[FLAG_FE]  = (state_q == ST_STOP2) ? (fe_q | ~vote_c) : ~vote_c;
    flags_c[FLAG_PE]  = pe_q;
  end

  // Synchroniser, sampler, frame datapath, overrun and timeout
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      rx_prev   <= 1'b1;
      tick_q    <= '0;
      samp_a    <= 1'b1;
      samp_b    <= 1'b1;
      bits_q    <= CFG_BITS_DEFAULT;
      pen_q     <= 1'b0;
      podd_q    <= 1'b0;
      two_q     <= 1'b0;
      msb_q     <= 1'b0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      zero_q    <= 1'b1;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      push_q    <= 1'b0;
      word_q    <= '0;
      ovr_q     <= 1'b0;
      to_q      <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      sync1   <= Rx_i;
      sync2   <= sync1;
      rx_prev <= sync2;

      if (start_edge_c)  tick_q <= '0;
      else if (AcqSig_i) tick_q <= (tick_q == TICK_W'(OVERSAMPLE - 1)) ? '0 : tick_q + TICK_W'(1);

      if (AcqSig_i && (tick_q == TICK_W'(MID - 1))) samp_a <= sync2;
      if (AcqSig_i && (tick_q == TICK_W'(MID)))     samp_b <= sync2;

      // Frame format is frozen for the whole character
      if (start_edge_c) begin
        bits_q    <= norm_bits(cfg_data_bits_i);
        pen_q     <= p_ParityEnable_i;
        podd_q    <= ParityMethod_i;
        two_q     <= p_TwoStop_i;
        msb_q     <= p_BigEnd_i;
        bit_idx_q <= '0;
        shreg_q   <= '0;
        zero_q    <= 1'b1;
        pe_q      <= 1'b0;
        fe_q      <= 1'b0;
      end

      if (decide_c) begin
        case (state_q)
          ST_DATA: begin
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_q + 4'd1;
            zero_q    <= zero_q & ~vote_c;
          end
          ST_PARITY: begin
            pe_q   <= vote_c ^ (^shreg_q) ^ podd_q;
            zero_q <= zero_q & ~vote_c;
          end
          ST_STOP1: fe_q <= ~vote_c;
          default: ;
        endcase
      end

      push_q <= frame_done_c;
      if (frame_done_c) word_q <= {flags_c, shreg_q};

      // A set wins over a simultaneous clear
      ovr_q <= (ovr_q & ~clr_overrun_i) | (push_q & full & ~pop_c);

      if (pop_c || start_edge_c || empty) begin
        to_cnt_q <= '0;
        to_q     <= 1'b0;
      end else begin
        if ((state_q == ST_IDLE) && bit_end_c && (to_cnt_q != TO_W'(TIMEOUT_BITS)))
          to_cnt_q <= to_cnt_q + TO_W'(1);
        if (to_cnt_q == TO_W'(TIMEOUT_BITS)) to_q <= 1'b1;
      end
    end
  end

  rx_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .pop   (pop_c),
    .wdata (word_q),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .level (level_o)
  );

  assign data_o           = head[DATA_W-1:0];
  assign flags_o          = head[WORD_W-1:DATA_W];
  assign p_empty_o        = empty;
  assign p_OverrunError_o = ovr_q;
  assign p_Timeout_o      = to_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine: directed bench for uart_rx_engine.
// One acquisition tick every 2 clocks, OVERSAMPLE=16, so one bit = 32 clocks.
module tb_uart_rx_engine;

  localparam int unsigned DW    = 9;
  localparam int unsigned OS    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TOB   = 40;
  localparam int          BIT   = 32;

  logic                    clk      = 1'b0;
  logic                    rst      = 1'b0;
  logic                    acq      = 1'b0;
  logic                    rx       = 1'b1;
  logic [3:0]              cfg_bits = 4'd8;
  logic                    par_en   = 1'b0;
  logic                    par_odd  = 1'b0;
  logic                    two_stop = 1'b0;
  logic                    big_end  = 1'b0;
  logic                    n_rd     = 1'b1;
  logic                    clr_ovr  = 1'b0;
  logic [DW-1:0]           data;
  logic [2:0]              flags;
  logic                    empty;
  logic [$clog2(DEPTH):0]  level;
  logic                    ovr;
  logic                    tmo;

  int n_checks = 0;
  int n_errors = 0;
  int push_clk = -1;
  int cnt;

  uart_rx_engine #(
    .DATA_W       (DW),
    .OVERSAMPLE   (OS),
    .FIFO_DEPTH   (DEPTH),
    .TIMEOUT_BITS (TOB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .AcqSig_i         (acq),
    .Rx_i             (rx),
    .cfg_data_bits_i  (cfg_bits),
    .p_ParityEnable_i (par_en),
    .ParityMethod_i   (par_odd),
    .p_TwoStop_i      (two_stop),
    .p_BigEnd_i       (big_end),
    .n_rd_i           (n_rd),
    .data_o           (data),
    .flags_o          (flags),
    .p_empty_o        (empty),
    .level_o          (level),
    .p_OverrunError_o (ovr),
    .clr_overrun_i    (clr_ovr),
    .p_Timeout_o      (tmo)
  );

  always #5 clk = ~clk;

  // Acquisition tick: high for every other rising edge
  initial forever begin
    @(negedge clk);
    acq = ~acq;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic align();
    while (acq !== 1'b1) step();
  endtask

  task automatic pop();
    n_rd = 1'b0;
    step();
    n_rd = 1'b1;
  endtask

  // Drive one character; gbit = frame bit index to glitch, pop_at = step to pop on
  task automatic send(input logic [8:0] val, input int nb, input bit pen, input bit podd,
                      input bit pinv, input int ns, input bit msb, input bit stop_v,
                      input int gbit, input int pop_at);
    logic       seq [16];
    int         nt;
    logic [3:0] lvl0;
    cfg_bits = 4'(nb);
    par_en   = pen;
    par_odd  = podd;
    two_stop = (ns == 2);
    big_end  = msb;
    nt = 0;
    seq[nt] = 1'b0; nt++;
    for (int i = 0; i < nb; i++) begin
      seq[nt] = msb ? val[nb-1-i] : val[i];
      nt++;
    end
    if (pen) begin
      seq[nt] = (^val) ^ podd ^ pinv;
      nt++;
    end
    seq[nt] = stop_v; nt++;
    if (ns == 2) begin
      seq[nt] = 1'b1;
      nt++;
    end
    align();
    lvl0 = 4'(level);
    push_clk = -1;
    for (int c = 0; c < nt * BIT; c++) begin
      rx = seq[c / BIT];
      if ((c / BIT == gbit) && ((c % BIT == 18) || (c % BIT == 19))) rx = ~seq[c / BIT];
      n_rd = (c == pop_at) ? 1'b0 : 1'b1;
      step();
      if ((push_clk < 0) && (4'(level) != lvl0)) push_clk = c;
    end
    rx   = 1'b1;
    n_rd = 1'b1;
  endtask

  initial begin
    // Reset values
    idle(4);
    check_eq("rst_data", 32'(data), 32'h0);
    check_eq("rst_flags", 32'(flags), 32'h0);
    check_eq("rst_empty", 32'(empty), 32'h1);
    check_eq("rst_level", 32'(level), 32'h0);
    check_eq("rst_ovr", 32'(ovr), 32'h0);
    check_eq("rst_tmo", 32'(tmo), 32'h0);
    rst = 1'b1;
    idle(4);

    // 8N1 LSB-first 0xA5
    send(9'h0A5, 8, 0, 0, 0, 1, 0, 1, -1, -1);
    check_eq("t1_push_clk", 32'(push_clk), 32'd311);
    check_eq("t1_data", 32'(data), 32'h0A5);
    check_eq("t1_flags", 32'(flags), 32'h0);
    check_eq("t1_level", 32'(level), 32'h1);
    check_eq("t1_empty", 32'(empty), 32'h0);
    idle(BIT);
    pop();
    check_eq("t1_level_pop", 32'(level), 32'h0);
    check_eq("t1_empty_pop", 32'(empty), 32'h1);

    // 7O2 MSB-first 0x5B, good then inverted parity
    send(9'h05B, 7, 1, 1, 0, 2, 1, 1, -1, -1);
    check_eq("t2_data", 32'(data), 32'h05B);
    check_eq("t2_flags", 32'(flags), 32'h0);
    idle(BIT);
    send(9'h05B, 7, 1, 1, 1, 2, 1, 1, -1, -1);
    check_eq("t2_level", 32'(level), 32'h2);
    idle(BIT);
    pop();
    check_eq("t2b_data", 32'(data), 32'h05B);
    check_eq("t2b_flags", 32'(flags), 32'h1);
    pop();

    // 8N1 0x3C with the stop bit low
    idle(BIT);
    send(9'h03C, 8, 0, 0, 0, 1, 0, 0, -1, -1);
    idle(BIT);
    check_eq("t3_data", 32'(data), 32'h03C);
    check_eq("t3_flags", 32'(flags), 32'h2);
    pop();

    // Line held low for two character times
    align();
    rx = 1'b0;
    idle(20 * BIT);
    check_eq("brk_level", 32'(level), 32'h1);
    check_eq("brk_data", 32'(data), 32'h0);
    check_eq("brk_flags", 32'(flags), 32'h6);
    rx = 1'b1;
    idle(3 * BIT);
    check_eq("brk_level_after", 32'(level), 32'h1);
    pop();
    check_eq("brk_level_pop", 32'(level), 32'h0);

    // False start: 4-tick low pulse
    align();
    rx = 1'b0;
    idle(8);
    rx = 1'b1;
    idle(3 * BIT);
    check_eq("fs_level", 32'(level), 32'h0);

    // One-tick glitch in the middle of data bit 3
    send(9'h05A, 8, 0, 0, 0, 1, 0, 1, 4, -1);
    idle(BIT);
    check_eq("gl_data", 32'(data), 32'h05A);
    check_eq("gl_flags", 32'(flags), 32'h0);
    pop();

    // Fill, overrun, clear, push+pop while full
    for (int k = 1; k <= 4; k++) begin
      send(9'(k), 8, 0, 0, 0, 1, 0, 1, -1, -1);
      idle(BIT);
    end
    check_eq("ov_level4", 32'(level), 32'h4);
    check_eq("ov_ovr0", 32'(ovr), 32'h0);
    send(9'h005, 8, 0, 0, 0, 1, 0, 1, -1, -1);
    idle(BIT);
    check_eq("ov_level_full", 32'(level), 32'h4);
    check_eq("ov_ovr1", 32'(ovr), 32'h1);
    check_eq("ov_head", 32'(data), 32'h001);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check_eq("ov_clr", 32'(ovr), 32'h0);
    send(9'h006, 8, 0, 0, 0, 1, 0, 1, -1, 310);
    idle(BIT);
    check_eq("pp_level", 32'(level), 32'h4);
    check_eq("pp_ovr", 32'(ovr), 32'h0);
    check_eq("pp_head", 32'(data), 32'h002);
    pop();
    pop();
    pop();
    check_eq("pp_last", 32'(data), 32'h006);
    pop();
    check_eq("pp_empty", 32'(empty), 32'h1);

    // Timeout after 40 idle bit-times, cleared by the pop
    idle(BIT);
    send(9'h077, 8, 0, 0, 0, 1, 0, 1, -1, -1);
    check_eq("to_pre", 32'(tmo), 32'h0);
    cnt = 0;
    while ((tmo !== 1'b1) && (cnt < 45 * BIT)) begin
      step();
      cnt++;
    end
    cnt = cnt + (10 * BIT - 1) - push_clk;
    check_eq("to_window", 32'((cnt >= 39 * BIT) && (cnt <= 41 * BIT)), 32'h1);
    check_eq("to_set", 32'(tmo), 32'h1);
    pop();
    check_eq("to_clr", 32'(tmo), 32'h0);

    // Reset in the middle of a data bit
    send(9'h042, 8, 0, 0, 0, 1, 0, 1, -1, -1);
    idle(BIT);
    check_eq("mr_level_pre", 32'(level), 32'h1);
    align();
    rx = 1'b0;
    idle(BIT);
    rx = 1'b1;
    idle(3 * BIT + 16);
    rst = 1'b0;
    step();
    check_eq("mr_data", 32'(data), 32'h0);
    check_eq("mr_flags", 32'(flags), 32'h0);
    check_eq("mr_empty", 32'(empty), 32'h1);
    check_eq("mr_level", 32'(level), 32'h0);
    check_eq("mr_ovr", 32'(ovr), 32'h0);
    check_eq("mr_tmo", 32'(tmo), 32'h0);
    rst = 1'b1;
    idle(3 * BIT);
    check_eq("mr_level_post", 32'(level), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
